// File: rtl/dmem_arbiter.sv
// Two-requester (CPU/DMA) data-memory arbiter: round-robin grant, one access at a time,
// 3-cycle arbitrate/access/acknowledge sequence with alignment checking and load formatting.
module dmem_arbiter #(
    parameter int FIRST_PRIO = 0
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req0,
    input  logic        req1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic        byte0,
    input  logic        byte1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,

    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        stall0,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_word_we,
    output logic        mem_byte_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_last;
    logic        r_ack0;
    logic        r_ack1;
    logic        r_err0;
    logic        r_err1;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    logic        w_busy;
    logic        w_sel1;
    logic        w_wr;
    logic        w_byte;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_misalign;
    logic [31:0] w_load;

    assign w_busy  = (r_state == BUSY0) || (r_state == BUSY1);
    assign w_sel1  = (r_state == BUSY1);

    // Payload is taken straight from the granted requester, which holds it until ack.
    assign w_wr    = w_sel1 ? wr1    : wr0;
    assign w_byte  = w_sel1 ? byte1  : byte0;
    assign w_addr  = w_sel1 ? addr1  : addr0;
    assign w_wdata = w_sel1 ? wdata1 : wdata0;

    assign w_misalign = w_busy && !w_byte && (w_addr[1:0] != 2'b00);

    always_comb begin
        w_load = mem_rdata;
        if (w_byte) begin
            case (w_addr[1:0])
                2'd0:    w_load = {24'h0, mem_rdata[7:0]};
                2'd1:    w_load = {24'h0, mem_rdata[15:8]};
                2'd2:    w_load = {24'h0, mem_rdata[23:16]};
                default: w_load = {24'h0, mem_rdata[31:24]};
            endcase
        end
    end

    assign mem_addr    = w_busy ? w_addr  : 32'h0;
    assign mem_wdata   = w_busy ? w_wdata : 32'h0;
    // Reset gates the enables so a reset landing mid-access never commits the write.
    assign mem_word_we = w_busy && w_wr && !w_byte && !w_misalign && !reset;
    assign mem_byte_we = w_busy && w_wr &&  w_byte && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_last   <= ~FIRST_PRIO[0];
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            r_rdata0 <= 32'h0;
            r_rdata1 <= 32'h0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req0 && req1)
                        r_state <= r_last ? BUSY0 : BUSY1;
                    else if (req0)
                        r_state <= BUSY0;
                    else if (req1)
                        r_state <= BUSY1;
                end
                BUSY0: begin
                    r_last <= 1'b0;
                    r_ack0 <= 1'b1;
                    r_err0 <= w_misalign;
                    if (!w_wr && !w_misalign)
                        r_rdata0 <= w_load;
                    r_state <= ACK;
                end
                BUSY1: begin
                    r_last <= 1'b1;
                    r_ack1 <= 1'b1;
                    r_err1 <= w_misalign;
                    if (!w_wr && !w_misalign)
                        r_rdata1 <= w_load;
                    r_state <= ACK;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack0   = r_ack0;
    assign ack1   = r_ack1;
    assign err0   = r_err0;
    assign err1   = r_err1;
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;
    assign stall0 = req0 && !r_ack0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level memory/requester model.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, req1, wr0, wr1, byte0, byte1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1, stall0;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_word_we, mem_byte_we;

    int n_chk = 0;
    int n_pass = 0;

    dmem_arbiter #(.FIRST_PRIO(0)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .byte0(byte0), .byte1(byte1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1), .stall0(stall0),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_word_we(mem_word_we), .mem_byte_we(mem_byte_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // 256-byte little-endian data memory with a bench back door for preloading.
    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic        tb_we = 1'b0;
    logic [5:0]  tb_idx = 6'd0;
    logic [31:0] tb_dat = 32'h0;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clock) begin
        if (tb_we)
            mem[tb_idx] <= tb_dat;
        else begin
            if (mem_word_we) mem[mem_addr[7:2]] <= mem_wdata;
            if (mem_byte_we) mem[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic poke(input int idx, input logic [31:0] d);
        tb_idx = idx[5:0];
        tb_dat = d;
        tb_we  = 1'b1;
        ref_mem[idx] = d;
        @(posedge clock); #1;
        tb_we = 1'b0;
    endtask

    task automatic set_req(input int i, input logic r, input logic w, input logic b,
                           input logic [31:0] a, input logic [31:0] d);
        if (i == 0) begin req0 = r; wr0 = w; byte0 = b; addr0 = a; wdata0 = d; end
        else        begin req1 = r; wr1 = w; byte1 = b; addr1 = a; wdata1 = d; end
    endtask

    // Holds one request until its ack (bounded), reporting what was observed.
    task automatic run_access(input int i, input logic w, input logic b,
                              input logic [31:0] a, input logic [31:0] d,
                              output int ack_c, output logic [31:0] rd, output logic er,
                              output int stall_hi, output int we_cnt, output int other_ack);
        ack_c = -1; rd = 32'h0; er = 1'b0; stall_hi = 0; we_cnt = 0; other_ack = 0;
        set_req(i, 1'b1, w, b, a, d);
        for (int c = 1; c <= 20 && ack_c < 0; c++) begin
            @(negedge clock);
            if (stall0) stall_hi++;
            if (mem_word_we || mem_byte_we) we_cnt++;
            if ((i == 0) ? ack1 : ack0) other_ack++;
            if ((i == 0) ? ack0 : ack1) begin
                ack_c = c;
                rd = (i == 0) ? rdata0 : rdata1;
                er = (i == 0) ? err0 : err1;
            end
            @(posedge clock); #1;
        end
        set_req(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clock); #1;
        for (int k = 0; k < 64; k++) poke(k, $urandom);
        @(negedge clock);
        n_chk++;
        if ({ack0, ack1, err0, err1, stall0, mem_word_we, mem_byte_we} !== 7'b0)
            $display("FAIL reset_flags: got %b expected 0000000",
                     {ack0, ack1, err0, err1, stall0, mem_word_we, mem_byte_we});
        else n_pass++;
        n_chk++;
        if (rdata0 !== 32'h0 || rdata1 !== 32'h0)
            $display("FAIL reset_rdata: got %h/%h expected 0/0", rdata0, rdata1);
        else n_pass++;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_tie;
        logic [1:0] exp_ack;
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h30, 32'h0BADF00D);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            exp_ack = {(c == 6 || c == 12), (c == 3 || c == 9)};
            n_chk++;
            if ({ack1, ack0} !== exp_ack)
                $display("FAIL tie_order cycle %0d: got ack1,ack0=%b expected %b", c, {ack1, ack0}, exp_ack);
            else n_pass++;
            @(posedge clock); #1;
        end
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_chk++;
        if (rdata0 !== ref_mem[4]) $display("FAIL tie_load: got %h expected %h", rdata0, ref_mem[4]);
        else n_pass++;
        n_chk++;
        if (mem[12] !== 32'h0BADF00D) $display("FAIL tie_store: got %h expected 0badf00d", mem[12]);
        else n_pass++;
        ref_mem[12] = 32'h0BADF00D;
    endtask

    task automatic test_word_load;
        int ac, sh, wc, oa; logic [31:0] rd; logic er;
        poke(4, 32'hDEADBEEF);
        run_access(0, 1'b0, 1'b0, 32'h10, 32'h0, ac, rd, er, sh, wc, oa);
        n_chk++; if (ac !== 3) $display("FAIL wl_ack_cycle: got %0d expected 3", ac); else n_pass++;
        n_chk++; if (rd !== 32'hDEADBEEF) $display("FAIL wl_rdata: got %h expected deadbeef", rd); else n_pass++;
        n_chk++; if (er !== 1'b0) $display("FAIL wl_err: got %b expected 0", er); else n_pass++;
        n_chk++; if (sh !== 2) $display("FAIL wl_stall: got %0d cycles expected 2", sh); else n_pass++;
        n_chk++; if (oa !== 0) $display("FAIL wl_other_ack: got %0d expected 0", oa); else n_pass++;
    endtask

    task automatic test_byte_store_word_load;
        int ac, sh, wc, oa; logic [31:0] rd; logic er;
        poke(4, 32'hDEADBEEF);
        run_access(1, 1'b1, 1'b1, 32'h13, 32'h000000AB, ac, rd, er, sh, wc, oa);
        n_chk++; if (ac !== 3) $display("FAIL bs_ack_cycle: got %0d expected 3", ac); else n_pass++;
        n_chk++; if (er !== 1'b0) $display("FAIL bs_err: got %b expected 0", er); else n_pass++;
        n_chk++; if (wc !== 1) $display("FAIL bs_we_cycles: got %0d expected 1", wc); else n_pass++;
        n_chk++; if (rd !== 32'h0) $display("FAIL bs_rdata_held: got %h expected 0", rd); else n_pass++;
        run_access(1, 1'b0, 1'b0, 32'h10, 32'h0, ac, rd, er, sh, wc, oa);
        n_chk++; if (ac !== 3) $display("FAIL bl_ack_cycle: got %0d expected 3", ac); else n_pass++;
        n_chk++; if (rd !== 32'hABADBEEF) $display("FAIL bl_rdata: got %h expected abadbeef", rd); else n_pass++;
        n_chk++; if (oa !== 0 || sh !== 0) $display("FAIL bl_side: got other_ack=%0d stall=%0d expected 0/0", oa, sh); else n_pass++;
        ref_mem[4] = 32'hABADBEEF;
    endtask

    task automatic test_misaligned;
        int ac, sh, wc, oa; logic [31:0] rd; logic er;
        poke(1, 32'h12345678);
        run_access(0, 1'b1, 1'b0, 32'h6, 32'hCAFEF00D, ac, rd, er, sh, wc, oa);
        n_chk++; if (ac !== 3) $display("FAIL mis_ack_cycle: got %0d expected 3", ac); else n_pass++;
        n_chk++; if (er !== 1'b1) $display("FAIL mis_err: got %b expected 1", er); else n_pass++;
        n_chk++; if (wc !== 0) $display("FAIL mis_we: got %0d cycles expected 0", wc); else n_pass++;
        n_chk++; if (mem[1] !== 32'h12345678) $display("FAIL mis_mem: got %h expected 12345678", mem[1]); else n_pass++;
        n_chk++; if (rd !== 32'hDEADBEEF) $display("FAIL mis_rdata_held: got %h expected deadbeef", rd); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp;
        poke(5, 32'h5A5A1234);
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            exp = (c % 3 == 0) ? 2'b10 : 2'b01;
            n_chk++;
            if ({ack0, stall0} !== exp)
                $display("FAIL b2b cycle %0d: got ack0,stall0=%b expected %b", c, {ack0, stall0}, exp);
            else n_pass++;
            @(posedge clock); #1;
        end
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_chk++;
        if (rdata0 !== 32'h5A5A1234) $display("FAIL b2b_rdata: got %h expected 5a5a1234", rdata0);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        poke(8, 32'h11111111);
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h55555555);
        @(posedge clock); #2;
        n_chk++;
        if (mem_word_we !== 1'b1) $display("FAIL rm_busy_we: got %b expected 1", mem_word_we);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_chk++;
        if ({mem_word_we, mem_byte_we} !== 2'b00) $display("FAIL rm_we_gated: got %b expected 00", {mem_word_we, mem_byte_we});
        else n_pass++;
        @(posedge clock); #1;
        reset = 1'b0;
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            if (c == 1) begin
                n_chk++;
                if ({ack0, ack1, err0, err1} !== 4'b0 || rdata0 !== 32'h0 || rdata1 !== 32'h0)
                    $display("FAIL rm_outputs: got ack/err=%b rdata=%h/%h expected 0000 0/0",
                             {ack0, ack1, err0, err1}, rdata0, rdata1);
                else n_pass++;
                n_chk++;
                if (mem[8] !== 32'h11111111) $display("FAIL rm_mem: got %h expected 11111111", mem[8]);
                else n_pass++;
            end
            n_chk++;
            if ({ack1, ack0} !== {1'b0, c == 3})
                $display("FAIL rm_restart cycle %0d: got ack1,ack0=%b expected %b", c, {ack1, ack0}, {1'b0, c == 3});
            else n_pass++;
            @(posedge clock); #1;
        end
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_chk++;
        if (rdata0 !== 32'hABADBEEF) $display("FAIL rm_rdata: got %h expected abadbeef", rdata0);
        else n_pass++;
    endtask

    task automatic test_random;
        logic        act [2];
        logic        pw [2];
        logic        pb [2];
        logic [31:0] pa [2];
        logic [31:0] pd [2];
        int          wt [2];
        logic [31:0] exp_rd [2];
        logic        a, e_err, g_err;
        logic [31:0] g_rd, wv;
        int          idx, bad;
        reset = 1'b1;
        @(posedge clock); #1;
        for (int k = 0; k < 64; k++) poke(k, $urandom);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; pw[i] = 1'b0; pb[i] = 1'b0; pa[i] = 32'h0; pd[i] = 32'h0;
            wt[i] = 0; exp_rd[i] = 32'h0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!act[i] && c < 370 && $urandom_range(0, 2) == 0) begin
                    act[i] = 1'b1; wt[i] = 0;
                    pw[i] = $urandom_range(0, 1) == 1;
                    pb[i] = $urandom_range(0, 1) == 1;
                    pa[i] = 32'($urandom_range(0, 255));
                    if (!pb[i] && $urandom_range(0, 2) != 0) pa[i][1:0] = 2'b00;
                    pd[i] = $urandom;
                end
                set_req(i, act[i], pw[i], pb[i], pa[i], pd[i]);
            end
            @(negedge clock);
            n_chk++;
            if (ack0 && ack1) $display("FAIL rnd_both_ack at cycle %0d: got 11 expected at most one", c);
            else n_pass++;
            for (int i = 0; i < 2; i++) begin
                a = (i == 0) ? ack0 : ack1;
                g_rd = (i == 0) ? rdata0 : rdata1;
                g_err = (i == 0) ? err0 : err1;
                if (act[i]) wt[i]++;
                if (a) begin
                    n_chk++;
                    if (!act[i]) begin
                        $display("FAIL rnd_spurious_ack%0d at cycle %0d: got ack expected none", i, c);
                        continue;
                    end
                    n_pass++;
                    idx = int'(pa[i][7:2]);
                    e_err = !pb[i] && (pa[i][1:0] != 2'b00);
                    if (!e_err && !pw[i]) begin
                        wv = ref_mem[idx];
                        exp_rd[i] = pb[i] ? ((wv >> (8 * int'(pa[i][1:0]))) & 32'hFF) : wv;
                    end else if (!e_err) begin
                        if (pb[i]) ref_mem[idx][8 * int'(pa[i][1:0]) +: 8] = pd[i][7:0];
                        else       ref_mem[idx] = pd[i];
                    end
                    n_chk++;
                    if (g_err !== e_err || g_rd !== exp_rd[i])
                        $display("FAIL rnd_result%0d cycle %0d: got err=%b rdata=%h expected err=%b rdata=%h",
                                 i, c, g_err, g_rd, e_err, exp_rd[i]);
                    else n_pass++;
                    n_chk++;
                    if (wt[i] > 6) $display("FAIL rnd_wait%0d: got %0d cycles expected <=6", i, wt[i]);
                    else n_pass++;
                    act[i] = 1'b0;
                end else if (act[i] && wt[i] > 6) begin
                    n_chk++;
                    $display("FAIL rnd_timeout%0d at cycle %0d: got no ack after %0d cycles expected <=6", i, c, wt[i]);
                    act[i] = 1'b0;
                end
            end
            @(posedge clock); #1;
        end
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        bad = 0;
        for (int k = 0; k < 64; k++) if (mem[k] !== ref_mem[k]) bad++;
        n_chk++;
        if (bad != 0) $display("FAIL rnd_mem_image: got %0d differing words expected 0", bad);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_tie;
        test_word_load;
        test_byte_store_word_load;
        test_misaligned;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
